// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Default-width entry; fetch_queue builds its own at its configured widths.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    localparam logic [31:0] NOP_INST = 32'h0;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of fetch entries with push, pop, flush and count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  T                           i_din,
    output T                           o_dout,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_dout  = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // Storage is cleared on reset so the head outputs are never X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Fetch stage: PC handshake, single-outstanding imem request and an
//            instruction FIFO with redirect flush. FETCH_ALIGN_CHECK_EN turns
//            misaligned PCs into fault entries instead of memory requests.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       MasterReset,
    input  logic [ADDR_W-1:0]          pc_in,
    input  logic                       pc_valid,
    output logic                       pc_ready,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       redirect,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [DATA_W-1:0]          inst_out,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic                       inst_fault,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic              fault;
    } slot_t;

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fault_pend;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_room;
    logic              w_push;
    logic [DATA_W-1:0] w_push_inst;
    slot_t             w_push_slot;
    slot_t             w_head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (pc_in[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_accept = pc_valid && pc_ready;

    // A pending fault entry has not reached the count yet, so reserve its slot.
    assign w_room = r_fault_pend ? (count < CNT_W'(DEPTH - 1))
                                 : (count < CNT_W'(DEPTH));

    always_ff @(posedge CLK) begin
        if (MasterReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_misaligned) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    w_next_state = IDLE;
                end else if (redirect) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        pc_ready = 1'b0;
        imem_req = 1'b0;
        w_push   = 1'b0;
        pc_ready = (r_state == IDLE) && w_room && !redirect && !MasterReset;
        imem_req = (r_state != IDLE);
        w_push   = !redirect && (((r_state == WAIT) && imem_ack) || r_fault_pend);
    end

    always_ff @(posedge CLK) begin
        if (MasterReset) begin
            r_addr       <= '0;
            r_pc         <= '0;
            r_fault_pend <= 1'b0;
        end else begin
            r_fault_pend <= w_accept && w_misaligned;
            if (w_accept) begin
                r_pc <= pc_in;
            end
            if (w_accept && !w_misaligned) begin
                r_addr <= {pc_in[ADDR_W-1:2], 2'b00};
            end
        end
    end

    assign imem_addr   = r_addr;
    assign w_push_inst = r_fault_pend ? DATA_W'(NOP_INST) : imem_rdata;
    assign w_push_slot = {r_pc, w_push_inst, r_fault_pend};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (slot_t)
    ) u_fifo (
        .clk     (CLK),
        .rst     (MasterReset),
        .i_push  (w_push),
        .i_pop   (inst_ready),
        .i_flush (redirect),
        .i_din   (w_push_slot),
        .o_dout  (w_head),
        .o_valid (inst_valid),
        .o_count (count)
    );

    assign inst_out   = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign inst_fault = w_head.fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Self-checking bench for fetch_queue: directed scenarios plus a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        MasterReset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .MasterReset(MasterReset), .pc_in(pc_in), .pc_valid(pc_valid),
        .pc_ready(pc_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .inst_fault(inst_fault), .count(count)
    );

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        MasterReset = 1'b1; pc_valid = 1'b0; imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        cyc(); cyc();
        MasterReset = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
        int n = 0;
        pc_in = pc; pc_valid = 1'b1; #1;
        while (pc_ready !== 1'b1) begin
            if (n == 30) begin
                checks++; errors++;
                $display("FAIL fetch_timeout: pc_ready=%b required 1 for pc %h", pc_ready, pc);
                pc_valid = 1'b0;
                return;
            end
            cyc(); n++;
        end
        cyc();
        pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = data;
        cyc();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        MasterReset = 1'b1; pc_valid = 1'b1; pc_in = 32'h1234_5678;
        cyc(); #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
        cyc();
        MasterReset = 1'b0; pc_valid = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        checks++; if (inst_out !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0)
            begin errors++; $display("FAIL reset_head: got %h/%h/%b want 0/0/0", inst_out, inst_pc, inst_fault); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    endtask

    task automatic test_single();
        do_reset();
        pc_in = 32'h0040_0000; pc_valid = 1'b1; #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", pc_ready); end
        cyc();
        pc_valid = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000)
            begin errors++; $display("FAIL single_req: got %b/%h want 1/00400000", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h8C08_0000;
        cyc();
        imem_ack = 1'b0; #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0000 || inst_out !== 32'h8C08_0000)
            begin errors++; $display("FAIL single_head: got %b/%h/%h want 1/00400000/8c080000", inst_valid, inst_pc, inst_out); end
        checks++; if (count !== 3'd1 || imem_req !== 1'b0)
            begin errors++; $display("FAIL single_count: got %0d/%b want 1/0", count, imem_req); end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0; #1;
        checks++; if (count !== 3'd0 || inst_valid !== 1'b0)
            begin errors++; $display("FAIL single_pop: got %0d/%b want 0/0", count, inst_valid); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        do_fetch(32'h1000, 32'h11);
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_fetch(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i));
        pc_in = 32'h2010; pc_valid = 1'b1; #1;
        checks++; if (count !== 3'd4 || pc_ready !== 1'b0)
            begin errors++; $display("FAIL full_state: got count %0d ready %b want 4/0", count, pc_ready); end
        repeat (3) cyc();
        #1;
        checks++; if (pc_ready !== 1'b0 || imem_req !== 1'b0 || count !== 3'd4)
            begin errors++; $display("FAIL full_hold: got %b/%b/%0d want 0/0/4", pc_ready, imem_req, count); end
        checks++; if (inst_pc !== 32'h2000 || inst_out !== 32'hA0)
            begin errors++; $display("FAIL full_head: got %h/%h want 2000/a0", inst_pc, inst_out); end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0; #1;
        checks++; if (count !== 3'd3 || pc_ready !== 1'b1)
            begin errors++; $display("FAIL full_release: got %0d/%b want 3/1", count, pc_ready); end
        cyc();
        pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hA4;
        cyc();
        imem_ack = 1'b0;
        for (int i = 1; i < 5; i++) begin
            #1;
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000 + 32'(4 * i) || inst_out !== 32'hA0 + 32'(i))
                begin errors++; $display("FAIL wrap_order[%0d]: got %b/%h/%h want 1/%h/%h", i, inst_valid, inst_pc, inst_out,
                                         32'h2000 + 32'(4 * i), 32'hA0 + 32'(i)); end
            inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
        end
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_redirect();
        do_reset();
        do_fetch(32'h3000, 32'h33);
        pc_in = 32'h3004; pc_valid = 1'b1; cyc();
        pc_valid = 1'b0; redirect = 1'b1; #1;
        checks++; if (pc_ready !== 1'b0 || imem_req !== 1'b1)
            begin errors++; $display("FAIL redir_cycle: got ready %b req %b want 0/1", pc_ready, imem_req); end
        cyc();
        redirect = 1'b0; #1;
        checks++; if (count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b1 || pc_ready !== 1'b0)
            begin errors++; $display("FAIL redir_flush: got %0d/%b/%b/%b want 0/0/1/0", count, inst_valid, imem_req, pc_ready); end
        cyc(); #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b want 0", pc_ready); end
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL drain_ack_ready: got %b want 0", pc_ready); end
        cyc();
        imem_ack = 1'b0; #1;
        checks++; if (pc_ready !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || count !== 3'd0)
            begin errors++; $display("FAIL drain_done: got %b/%b/%b/%0d want 1/0/0/0", pc_ready, imem_req, inst_valid, count); end
    endtask

    task automatic test_push_pop();
        do_reset();
        do_fetch(32'h4000, 32'h40);
        do_fetch(32'h4004, 32'h44);
        pc_in = 32'h4008; pc_valid = 1'b1; #1;
        checks++; if (pc_ready !== 1'b1 || count !== 3'd2)
            begin errors++; $display("FAIL pp_pre: got %b/%0d want 1/2", pc_ready, count); end
        cyc();
        pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h48; inst_ready = 1'b1;
        cyc();
        imem_ack = 1'b0; inst_ready = 1'b0; #1;
        checks++; if (count !== 3'd2 || inst_pc !== 32'h4004 || inst_out !== 32'h44)
            begin errors++; $display("FAIL pp_same: got %0d/%h/%h want 2/4004/44", count, inst_pc, inst_out); end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0; #1;
        checks++; if (count !== 3'd1 || inst_pc !== 32'h4008 || inst_out !== 32'h48)
            begin errors++; $display("FAIL pp_next: got %0d/%h/%h want 1/4008/48", count, inst_pc, inst_out); end
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        do_fetch(32'h5000, 32'h55);
        pc_in = 32'h5004; pc_valid = 1'b1; cyc();
        pc_valid = 1'b0; MasterReset = 1'b1; #1;
        checks++; if (pc_ready !== 1'b0 || imem_req !== 1'b1)
            begin errors++; $display("FAIL rst_mid_cycle: got %b/%b want 0/1", pc_ready, imem_req); end
        cyc();
        MasterReset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h99; #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || count !== 3'd0)
            begin errors++; $display("FAIL rst_mid_req: got %b/%h/%0d want 0/0/0", imem_req, imem_addr, count); end
        cyc();
        imem_ack = 1'b0; #1;
        checks++; if (count !== 3'd0 || inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0)
            begin errors++; $display("FAIL rst_stray_ack: got %0d/%b/%h/%h/%b want all 0", count, inst_valid, inst_out, inst_pc, inst_fault); end
        checks++; if (imem_req !== 1'b0 || pc_ready !== 1'b1)
            begin errors++; $display("FAIL rst_idle: got req %b ready %b want 0/1", imem_req, pc_ready); end
    endtask

    task automatic test_align();
        do_reset();
        pc_in = 32'h0040_0002; pc_valid = 1'b1; cyc();
        pc_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0)
            begin errors++; $display("FAIL align_noreq: got %b/%b want 0/0", imem_req, inst_valid); end
        cyc(); #1;
        checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst_out !== 32'h0 || inst_pc !== 32'h0040_0002)
            begin errors++; $display("FAIL align_fault: got %b/%b/%h/%h want 1/1/0/00400002", inst_valid, inst_fault, inst_out, inst_pc); end
        checks++; if (imem_req !== 1'b0 || count !== 3'd1)
            begin errors++; $display("FAIL align_state: got %b/%0d want 0/1", imem_req, count); end
`else
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000)
            begin errors++; $display("FAIL align_addr: got %b/%h want 1/00400000", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; cyc();
        imem_ack = 1'b0; #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0002 || inst_out !== 32'h1234_5678 || inst_fault !== 1'b0)
            begin errors++; $display("FAIL align_entry: got %b/%h/%h/%b want 1/00400002/12345678/0", inst_valid, inst_pc, inst_out, inst_fault); end
`endif
        inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    endtask

    task automatic test_random();
        logic        out_pend = 1'b0, discard = 1'b0, fault_pend = 1'b0;
        logic        acc, pop, quiet, mis, exp_ready;
        logic [31:0] out_pc = '0, fault_pc = '0, pc;
        int          dly = 0;
        exp_t        e;
        do_reset();
        exp_q.delete();
        for (int cy = 0; cy < 400; cy++) begin
            quiet = (cy >= 370);
            checks++; if (int'(count) !== exp_q.size() || inst_valid !== (exp_q.size() != 0))
                begin errors++; $display("FAIL rnd_count@%0d: got %0d/%b want %0d", cy, count, inst_valid, exp_q.size()); end
            if (exp_q.size() != 0) begin
                checks++; if (inst_pc !== exp_q[0].pc || inst_out !== exp_q[0].inst || inst_fault !== exp_q[0].fault)
                    begin errors++; $display("FAIL rnd_head@%0d: got %h/%h/%b want %h/%h/%b", cy, inst_pc, inst_out, inst_fault,
                                             exp_q[0].pc, exp_q[0].inst, exp_q[0].fault); end
            end
            checks++; if (imem_req !== out_pend || (out_pend && imem_addr !== {out_pc[31:2], 2'b00}))
                begin errors++; $display("FAIL rnd_req@%0d: got %b/%h want %b/%h", cy, imem_req, imem_addr, out_pend, {out_pc[31:2], 2'b00}); end
            redirect   = !quiet && ($urandom_range(0, 15) == 0);
            pc_valid   = !quiet && ($urandom_range(0, 2) != 0);
            pc         = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            pc_in      = pc;
            inst_ready = quiet || ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            if (out_pend) begin
                imem_ack = (dly == 0);
                if (dly > 0) dly--;
            end else begin
                imem_ack = ($urandom_range(0, 7) == 0);
            end
            #1;
            exp_ready = !out_pend && !redirect && ((exp_q.size() + (fault_pend ? 1 : 0)) < DEPTH);
            checks++; if (pc_ready !== exp_ready)
                begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cy, pc_ready, exp_ready); end
            acc = pc_valid && pc_ready;
`ifdef FETCH_ALIGN_CHECK_EN
            mis = (pc[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            pop = (exp_q.size() != 0) && inst_ready;
            if (redirect) begin
                exp_q.delete();
                fault_pend = 1'b0;
                if (out_pend && imem_ack) begin out_pend = 1'b0; discard = 1'b0; end
                else if (out_pend) discard = 1'b1;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (fault_pend) begin e.pc = fault_pc; e.inst = 32'h0; e.fault = 1'b1; exp_q.push_back(e); end
                if (out_pend && imem_ack) begin
                    if (!discard) begin e.pc = out_pc; e.inst = imem_rdata; e.fault = 1'b0; exp_q.push_back(e); end
                    out_pend = 1'b0; discard = 1'b0;
                end
                fault_pend = acc && mis;
                if (acc && mis) fault_pc = pc;
                if (acc && !mis) begin out_pend = 1'b1; out_pc = pc; dly = $urandom_range(0, 3); end
            end
            cyc();
        end
        pc_valid = 1'b0; inst_ready = 1'b0; imem_ack = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        MasterReset = 1'b1; pc_in = '0; pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rdata = '0; redirect = 1'b0; inst_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill_wrap();
        test_redirect();
        test_push_pop();
        test_reset_mid_wait();
        test_align();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
